// File: rtl/input_port_bank_pkg.sv
// Shared constants and helpers for the input port bank register window.
package input_port_bank_pkg;

  localparam logic [1:0] REG_LEVEL  = 2'd0;
  localparam logic [1:0] REG_RISE   = 2'd1;
  localparam logic [1:0] REG_FALL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  function automatic logic [7:0] status_byte(input logic any_rise, input logic any_fall);
    return {6'b0, any_fall, any_rise};
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One pin: synchroniser chain, debounce counter and debounced level register.
module input_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value seen on the last of DEBOUNCE_CYCLES consecutive differing cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sync_out, differ, fire;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differ   = sync_out ^ level_q;
  assign fire     = differ && (cnt_q == CntLast);

  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    level_d = level_q;
    if (!differ) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d   = '0;
      level_d = sync_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = fire & sync_out;
  assign fall_pulse = fire & ~sync_out;

endmodule

// File: rtl/input_port_bank.sv
// Debounced multi-pin input port on INBUS: level, sticky edge flags (read-to-clear), status, IRQ.
module input_port_bank
  import input_port_bank_pkg::*;
#(
  parameter int unsigned PIN_WIDTH       = 8,
  parameter logic [7:0]  BASE_ADDRESS    = 8'h00,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           INBUS_ADDR,
  input  logic                 INBUS_RE,
  output logic [7:0]           INBUS_DATA,
  input  logic [PIN_WIDTH-1:0] INPUT_PIN,
  output logic                 IRQ
);

  logic [PIN_WIDTH-1:0] level, rise_pulse, fall_pulse;
  logic [PIN_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [7:0]           data_q, data_d, rd_mux;
  logic [1:0]           offset;
  logic                 rd_sel, clr_rise, clr_fall;

  for (genvar i = 0; i < PIN_WIDTH; i++) begin : g_pin
    input_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .pin       (INPUT_PIN[i]),
      .level     (level[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  assign offset   = INBUS_ADDR[1:0];
  assign rd_sel   = INBUS_RE && (INBUS_ADDR[7:2] == BASE_ADDRESS[7:2]);
  assign clr_rise = rd_sel && (offset == REG_RISE);
  assign clr_fall = rd_sel && (offset == REG_FALL);

  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_LEVEL:  rd_mux = 8'(level);
      REG_RISE:   rd_mux = 8'(rise_q);
      REG_FALL:   rd_mux = 8'(fall_q);
      REG_STATUS: rd_mux = status_byte(|rise_q, |fall_q);
      default:    rd_mux = '0;
    endcase
  end

  // A new edge arriving on the clearing edge survives the clear.
  always_comb begin
    rise_d = (rise_q & ~{PIN_WIDTH{clr_rise}}) | rise_pulse;
    fall_d = (fall_q & ~{PIN_WIDTH{clr_fall}}) | fall_pulse;
    data_d = rd_sel ? rd_mux : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
      data_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      data_q <= data_d;
    end
  end

  assign INBUS_DATA = data_q;
  assign IRQ        = (|rise_q) | (|fall_q);

endmodule

// File: tb/tb_input_port_bank.sv
// Self-checking bench: directed tables, multi-cycle corner sequences and a random run
// compared against a sliding-window reference model.
module tb_input_port_bank;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr = '0;
  logic       re = 1'b0;
  logic [7:0] pins = '0;
  logic [7:0] data;
  logic       irq;

  logic       reset3 = 1'b1;
  logic [7:0] addr3 = '0;
  logic       re3 = 1'b0;
  logic [2:0] pins3 = '0;
  logic [7:0] data3;
  logic       irq3;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  input_port_bank dut (
    .clk       (clk),
    .reset     (reset),
    .INBUS_ADDR(addr),
    .INBUS_RE  (re),
    .INBUS_DATA(data),
    .INPUT_PIN (pins),
    .IRQ       (irq)
  );

  input_port_bank #(
    .PIN_WIDTH   (3),
    .BASE_ADDRESS(8'h40)
  ) dut3 (
    .clk       (clk),
    .reset     (reset3),
    .INBUS_ADDR(addr3),
    .INBUS_RE  (re3),
    .INBUS_DATA(data3),
    .INPUT_PIN (pins3),
    .IRQ       (irq3)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pins are delayed SYNC edges, and a bit's level flips once the last DEB
  // delayed samples all disagree with it.
  logic [7:0] m_pipe [SYNC];
  logic [7:0] m_hist [$];
  logic [7:0] m_level = '0, m_rise = '0, m_fall = '0, m_data = '0;

  initial begin
    logic [7:0] s, fire, clr_r, clr_f;
    for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
        m_hist.delete();
        m_level = '0; m_rise = '0; m_fall = '0; m_data = '0;
      end else begin
        s = m_pipe[SYNC-1];
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        fire = '0;
        if (m_hist.size() == DEB) begin
          fire = 8'hFF;
          foreach (m_hist[k]) fire = fire & (m_hist[k] ^ m_level);
        end
        clr_r = '0; clr_f = '0; m_data = '0;
        if (re && addr[7:2] == 6'd0) begin
          case (addr[1:0])
            2'd0: m_data = m_level;
            2'd1: begin m_data = m_rise; clr_r = 8'hFF; end
            2'd2: begin m_data = m_fall; clr_f = 8'hFF; end
            default: m_data = {6'd0, |m_fall, |m_rise};
          endcase
        end
        m_rise  = (m_rise & ~clr_r) | (fire & s);
        m_fall  = (m_fall & ~clr_f) | (fire & ~s);
        m_level = m_level ^ fire;
        for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = pins;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_data", data, m_data);
        check("model_irq", {7'd0, irq}, {7'd0, (|m_rise) | (|m_fall)});
      end
    end
  end

  task automatic do_read(input logic [7:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = data;
  endtask

  task automatic read3(input logic [7:0] a, output logic [7:0] d);
    addr3 = a; re3 = 1'b1;
    @(negedge clk);
    re3 = 1'b0;
    d = data3;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp;
    string      name;
  } vec_t;

  initial begin
    vec_t       t0 [4];
    vec_t       t3 [5];
    logic [7:0] d;

    t0 = '{'{8'h00, 8'h00, "rst_level"}, '{8'h01, 8'h00, "rst_rise"},
           '{8'h02, 8'h00, "rst_fall"},  '{8'h03, 8'h00, "rst_status"}};
    t3 = '{'{8'h40, 8'h07, "w3_level"},  '{8'h44, 8'h00, "w3_unsel"},
           '{8'h43, 8'h01, "w3_status"}, '{8'h42, 8'h00, "w3_fall"},
           '{8'h3c, 8'h00, "w3_below"}};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    foreach (t0[i]) begin
      do_read(t0[i].a, d);
      check(t0[i].name, d, t0[i].exp);
    end
    check("rst_irq", {7'd0, irq}, 8'h00);

    // Clean step: level changes SYNC+DEB edges after the first sampling edge.
    pins = 8'h05;
    repeat (5) @(negedge clk);
    check("step_irq_early", {7'd0, irq}, 8'h00);
    @(negedge clk);
    check("step_irq", {7'd0, irq}, 8'h01);
    do_read(8'h00, d); check("step_level", d, 8'h05);
    do_read(8'h01, d); check("step_rise", d, 8'h05);
    do_read(8'h01, d); check("step_rise_clr", d, 8'h00);
    check("step_irq_clr", {7'd0, irq}, 8'h00);

    // 3-cycle glitch on bit 7 is filtered out.
    pins = 8'h85;
    repeat (3) @(negedge clk);
    pins = 8'h05;
    repeat (10) @(negedge clk);
    check("glitch_irq", {7'd0, irq}, 8'h00);
    do_read(8'h00, d); check("glitch_level", d, 8'h05);
    do_read(8'h01, d); check("glitch_rise", d, 8'h00);
    do_read(8'h02, d); check("glitch_fall", d, 8'h00);

    // Falling bit 0; STATUS read must not clear FALL.
    pins = 8'h04;
    repeat (8) @(negedge clk);
    do_read(8'h03, d); check("fall_status", d, 8'h02);
    do_read(8'h02, d); check("fall_flags", d, 8'h01);
    do_read(8'h02, d); check("fall_clr", d, 8'h00);

    // RISE read on the very edge bit 3 rises: old flags returned, new flag kept.
    pins = 8'h0C;
    repeat (5) @(negedge clk);
    do_read(8'h01, d); check("setwins_old", d, 8'h00);
    check("setwins_irq", {7'd0, irq}, 8'h01);
    do_read(8'h01, d); check("setwins_new", d, 8'h08);
    check("setwins_irq_clr", {7'd0, irq}, 8'h00);

    // Random run against the model, with occasional asynchronous resets.
    repeat (3000) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      if ($urandom_range(0, 4) == 0) pins = 8'($urandom);
      re = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      if (!reset && $urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0; re = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    // Narrow instance at a non-zero base address.
    reset3 = 1'b0;
    pins3 = 3'b111;
    repeat (10) @(negedge clk);
    foreach (t3[i]) begin
      read3(t3[i].a, d);
      check(t3[i].name, d, t3[i].exp);
    end
    check("w3_irq", {7'd0, irq3}, 8'h01);

    // Asynchronous reset in the middle of a debounce window.
    pins3 = 3'b000;
    repeat (3) @(negedge clk);
    addr3 = 8'h40; re3 = 1'b1;
    @(posedge clk);
    #2 re3 = 1'b0;
    check("w3_pre_rst_data", data3, 8'h07);
    reset3 = 1'b1;
    #1;
    check("w3_rst_data", data3, 8'h00);
    check("w3_rst_irq", {7'd0, irq3}, 8'h00);
    @(negedge clk);
    reset3 = 1'b0;
    repeat (12) @(negedge clk);
    read3(8'h43, d); check("w3_post_status", d, 8'h00);
    read3(8'h40, d); check("w3_post_level", d, 8'h00);
    read3(8'h42, d); check("w3_post_fall", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_port_bank.md
# input_port_bank

Multi-bit, memory-mapped input port for the processor's read bus (INBUS). It samples up to 8 asynchronous external pins through a synchroniser and a per-bit debounce filter, and exposes four read-only registers: debounced level, sticky rising-edge flags, sticky falling-edge flags, and a pending summary. Edge flags are cleared on read, and an IRQ output signals any pending edge. It replaces single-bit, level-only pin readers on the same bus.

## Interface
- PIN_WIDTH, 8 — number of pins, 1..8; register bits above PIN_WIDTH read 0.
- BASE_ADDRESS, 8'h00 — base of a 4-register window; bits [1:0] must be 0.
- SYNC_STAGES, 2 — synchroniser flops per pin, 2..4.
- DEBOUNCE_CYCLES, 4 — consecutive stable cycles required before the level changes, 1..65535; 1 means no filtering.

- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- INBUS_ADDR  in  8  read address
- INBUS_RE  in  1  read strobe, one cycle per read
- INBUS_DATA  out  8  registered read data; 0 when not selected (OR-combined bus)
- INPUT_PIN  in  PIN_WIDTH  asynchronous external pins
- IRQ  out  1  high while any edge flag is set

## Operation
- Register map, offset = INBUS_ADDR[1:0], selected when INBUS_ADDR[7:2] == BASE_ADDRESS[7:2]:
  - 0 LEVEL: debounced level, no side effects.
  - 1 RISE: sticky rising flags, read-to-clear.
  - 2 FALL: sticky falling flags, read-to-clear.
  - 3 STATUS: bit0 = |RISE, bit1 = |FALL, bits 7:2 = 0; no side effects.
- Per-bit pipeline:
  - The synchroniser chain feeds the debounce counter, then the debounced level register.
  - Counter behaviour: it resets to 0 on any cycle where the sync output equals the level. Otherwise it increments.
  - Level update: on the clock edge where the sync output has differed for DEBOUNCE_CYCLES consecutive cycles, the level takes the sync value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge flags:
  - A level change 0→1 sets the RISE bit; 1→0 sets the FALL bit, on the same edge the level changes.
  - Flags hold until cleared by a read.
- Read-to-clear:
  - A selected read of RISE or FALL returns the current flags.
  - On the same edge, all flag bits of that register clear, except bits being set on that edge. Set wins; the new edge is reported on the next read.
- IRQ = |RISE | |FALL, taken directly from the flag registers.
- Reset values: all sync flops, counters, levels, flags, INBUS_DATA and IRQ are 0. A pin held high through reset therefore produces a RISE flag after the first debounce window.
- Reset mid-count discards the partial count. Unselected reads and reads with INBUS_RE low change no state.

## Timing
- Read latency: INBUS_DATA is valid the cycle after INBUS_RE is sampled with a matching address. Otherwise INBUS_DATA is 0 on every cycle.
- Pin-to-level latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks after the first edge that samples the new pin value, for a clean step.
- A pulse shorter than DEBOUNCE_CYCLES at the sync output is ignored.
- IRQ rises in the cycle the flag register is set. IRQ falls the cycle after the clearing read, unless the other register or a set-wins bit remains.
- Back-to-back reads (INBUS_RE on consecutive cycles) are supported; each is handled independently.

## Structure
- Shared package/header holds the offset constants: REG_LEVEL=2'd0, REG_RISE=2'd1, REG_FALL=2'd2, REG_STATUS=2'd3.
- One sub-module, input_debounce, is instantiated PIN_WIDTH times:
  - It contains the synchroniser, counter and level register.
  - Outputs: level, rise_pulse, fall_pulse.
- The top level holds address decode, flag registers, read mux/register and IRQ.

## Test plan
- Reset with INPUT_PIN=8'h00, then read offsets 0..3 → all return 8'h00; IRQ=0.
- Defaults: step INPUT_PIN to 8'h05 and hold. LEVEL reads 8'h05 from 6 clocks later, and RISE=8'h05, IRQ=1 from the same edge. Read RISE → 8'h05; next read → 8'h00; IRQ=0.
- 3-cycle glitch on bit 7 with DEBOUNCE_CYCLES=4 → LEVEL, RISE and FALL all unchanged; IRQ stays 0.
- Bit 0 falls 1→0 → FALL=8'h01 and STATUS=8'h02; reading STATUS leaves FALL at 8'h01.
- A read of RISE on the same edge that bit 3 rises returns the old flags (8'h00). The next read returns 8'h08 (set wins).
- PIN_WIDTH=3, BASE_ADDRESS=8'h40, INPUT_PIN=3'b111 settled:
  - Read 8'h40 → 8'h07.
  - Read 8'h44 → 0, unselected.
  - Assert reset mid-debounce → all outputs 0 immediately, with no clock edge needed.
